// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use/branch/memory-wait hazard control with EX operand forwarding
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 32
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [4:0]       Rs_ID,
  input  logic [4:0]       Rt_ID,
  input  logic [4:0]       Rs_EX,
  input  logic [4:0]       Rt_EX,
  input  logic             R_Enable_EX,
  input  logic             BranchTaken_EX,
  input  logic             RegWrite_MEM,
  input  logic [4:0]       WriteReg_MEM,
  input  logic             RegWrite_WB,
  input  logic [4:0]       WriteReg_WB,
  input  logic             MemBusy_MEM,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IDEX_Write,
  output logic             EXMEM_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             MEMWB_Bubble,
  output logic [1:0]       ForwardA_EX,
  output logic [1:0]       ForwardB_EX,
  output logic             Timeout,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int WAIT_W = ($clog2(MAX_WAIT + 1) > 8) ? $clog2(MAX_WAIT + 1) : 8;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {RUN, LU_BUBBLE, MEM_WAIT} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              lu_hazard;

  assign lu_hazard = R_Enable_EX && (Rt_EX != 5'd0) &&
                     ((Rt_EX == Rs_ID) || (Rt_EX == Rt_ID));

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= RUN;
    else          state <= state_nxt;
  end

  // A load-use seen while already in the bubble does not re-enter it.
  always_comb begin
    state_nxt = RUN;
    if (MemBusy_MEM)
      state_nxt = MEM_WAIT;
    else if (!BranchTaken_EX && lu_hazard && (state != LU_BUBBLE))
      state_nxt = LU_BUBBLE;
  end

  always_comb begin
    PCWrite      = 1'b1;
    IFID_Write   = 1'b1;
    IDEX_Write   = 1'b1;
    EXMEM_Write  = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Flush   = 1'b0;
    MEMWB_Bubble = 1'b0;
    if (!Reset_n) begin
      PCWrite      = 1'b0;
      IFID_Write   = 1'b0;
      IDEX_Write   = 1'b0;
      EXMEM_Write  = 1'b0;
      IFID_Flush   = 1'b1;
      IDEX_Flush   = 1'b1;
      MEMWB_Bubble = 1'b1;
    end else if (MemBusy_MEM) begin
      PCWrite      = 1'b0;
      IFID_Write   = 1'b0;
      IDEX_Write   = 1'b0;
      EXMEM_Write  = 1'b0;
      MEMWB_Bubble = 1'b1;
    end else if (BranchTaken_EX) begin
      IFID_Flush   = 1'b1;
      IDEX_Flush   = 1'b1;
    end else if (lu_hazard) begin
      PCWrite      = 1'b0;
      IFID_Write   = 1'b0;
      IDEX_Flush   = 1'b1;
    end
  end

  // Wait counter tracks consecutive busy cycles, including the one that entered MEM_WAIT.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      wait_cnt <= '0;
      Timeout  <= 1'b0;
    end else begin
      if (!MemBusy_MEM)
        wait_cnt <= '0;
      else if (wait_cnt != {WAIT_W{1'b1}})
        wait_cnt <= wait_cnt + WAIT_W'(1);
      if (MemBusy_MEM && (state == MEM_WAIT) && (wait_cnt >= WAIT_LIMIT))
        Timeout <= 1'b1;
    end
  end

  always_comb begin
    ForwardA_EX = 2'b00;
    ForwardB_EX = 2'b00;
    if (Reset_n) begin
      if (RegWrite_MEM && (WriteReg_MEM != 5'd0) && (WriteReg_MEM == Rs_EX))
        ForwardA_EX = 2'b10;
      else if (RegWrite_WB && (WriteReg_WB != 5'd0) && (WriteReg_WB == Rs_EX))
        ForwardA_EX = 2'b01;
      if (RegWrite_MEM && (WriteReg_MEM != 5'd0) && (WriteReg_MEM == Rt_EX))
        ForwardB_EX = 2'b10;
      else if (RegWrite_WB && (WriteReg_WB != 5'd0) && (WriteReg_WB == Rt_EX))
        ForwardB_EX = 2'b01;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (!PCWrite)  StallCount <= StallCount + CNT_W'(1);
      if (IFID_Flush) FlushCount <= FlushCount + CNT_W'(1);
    end
  end
`else
  assign StallCount = '0;
  assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
// Counter expectations follow HAZARD_PERF_CNT_EN when it is defined for the build.
module tb_pipeline_hazard_ctrl;

  localparam int MAX_WAIT = 255;
  localparam int CNT_W    = 32;

  logic             Clock = 1'b0;
  logic             Reset_n;
  logic [4:0]       Rs_ID, Rt_ID, Rs_EX, Rt_EX, WriteReg_MEM, WriteReg_WB;
  logic             R_Enable_EX, BranchTaken_EX, RegWrite_MEM, RegWrite_WB, MemBusy_MEM;
  logic             PCWrite, IFID_Write, IDEX_Write, EXMEM_Write;
  logic             IFID_Flush, IDEX_Flush, MEMWB_Bubble, Timeout;
  logic [1:0]       ForwardA_EX, ForwardB_EX;
  logic [CNT_W-1:0] StallCount, FlushCount;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  int          streak;
  bit          to_m;
  int unsigned stall_m, flush_m;

  pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .Rs_EX(Rs_EX), .Rt_EX(Rt_EX),
    .R_Enable_EX(R_Enable_EX), .BranchTaken_EX(BranchTaken_EX),
    .RegWrite_MEM(RegWrite_MEM), .WriteReg_MEM(WriteReg_MEM),
    .RegWrite_WB(RegWrite_WB), .WriteReg_WB(WriteReg_WB),
    .MemBusy_MEM(MemBusy_MEM),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IDEX_Write(IDEX_Write),
    .EXMEM_Write(EXMEM_Write), .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
    .MEMWB_Bubble(MEMWB_Bubble), .ForwardA_EX(ForwardA_EX), .ForwardB_EX(ForwardB_EX),
    .Timeout(Timeout), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {PCWrite, IFID_Write, IDEX_Write, EXMEM_Write, IFID_Flush, IDEX_Flush, MEMWB_Bubble}
  function automatic logic [6:0] exp_ctrl();
    bit lu;
    lu = R_Enable_EX && Rt_EX != 0 && (Rt_EX == Rs_ID || Rt_EX == Rt_ID);
    if (!Reset_n)       return 7'b0000_111;
    if (MemBusy_MEM)    return 7'b0000_001;
    if (BranchTaken_EX) return 7'b1111_110;
    if (lu)             return 7'b0011_010;
    return 7'b1111_000;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    if (!Reset_n || src == 0) return 2'b00;
    if (RegWrite_MEM && WriteReg_MEM == src) return 2'b10;
    if (RegWrite_WB && WriteReg_WB == src) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      streak = 0; to_m = 0; stall_m = 0; flush_m = 0;
    end else begin
      logic [6:0] c;
      c = exp_ctrl();
      if (!c[6]) stall_m++;
      if (c[2])  flush_m++;
      if (MemBusy_MEM) begin
        streak++;
        if (streak > MAX_WAIT) to_m = 1;
      end else streak = 0;
    end
  end

  always @(negedge Clock) begin
    if (cmp_en) begin
      check("ctrl", {PCWrite, IFID_Write, IDEX_Write, EXMEM_Write, IFID_Flush, IDEX_Flush, MEMWB_Bubble}, exp_ctrl());
      check("fwd", {ForwardA_EX, ForwardB_EX}, {exp_fwd(Rs_EX), exp_fwd(Rt_EX)});
      check("timeout", Timeout, to_m);
`ifdef HAZARD_PERF_CNT_EN
      check("counts", {StallCount, FlushCount}, {stall_m[CNT_W-1:0], flush_m[CNT_W-1:0]});
`else
      check("counts", {StallCount, FlushCount}, '0);
`endif
    end
  end

  task automatic set_in(input logic [4:0] rs_id, rt_id, rs_ex, rt_ex, input logic ren, br,
                        input logic rw_m, input logic [4:0] wr_m, input logic rw_w,
                        input logic [4:0] wr_w, input logic busy);
    Rs_ID = rs_id; Rt_ID = rt_id; Rs_EX = rs_ex; Rt_EX = rt_ex;
    R_Enable_EX = ren; BranchTaken_EX = br;
    RegWrite_MEM = rw_m; WriteReg_MEM = wr_m; RegWrite_WB = rw_w; WriteReg_WB = wr_w;
    MemBusy_MEM = busy;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset_n = 1'b0;
    idle();
    cmp_en = 1'b1;
    @(negedge Clock);
    check("rst_pcwrite", PCWrite, 1'b0);
    check("rst_flush", {IFID_Flush, IDEX_Flush, MEMWB_Bubble}, 3'b111);
    check("rst_timeout", Timeout, 1'b0);
    tick(2);
    Reset_n = 1'b1;
    tick();

    set_in(5, 3, 1, 5, 1, 0, 0, 0, 0, 0, 0);
    @(negedge Clock);
    check("lu_stall", {PCWrite, IFID_Write, IDEX_Flush}, 3'b001);
    tick();
    idle();
    @(negedge Clock);
    check("lu_release", PCWrite, 1'b1);
    tick();

    set_in(0, 3, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    @(negedge Clock);
    check("lu_r0", PCWrite, 1'b1);
    tick();
    set_in(2, 9, 1, 9, 1, 0, 0, 0, 0, 0, 0);
    @(negedge Clock);
    check("lu_rt", PCWrite, 1'b0);
    tick();

    set_in(5, 3, 1, 5, 1, 1, 0, 0, 0, 0, 0);
    @(negedge Clock);
    check("lu_branch", {PCWrite, IFID_Flush, IDEX_Flush}, 3'b111);
    tick();
    set_in(5, 3, 1, 5, 1, 1, 0, 0, 0, 0, 1);
    @(negedge Clock);
    check("busy_prio", {PCWrite, EXMEM_Write, IFID_Flush, MEMWB_Bubble}, 4'b0001);
    tick();
    idle();
    tick();

    set_in(0, 0, 7, 0, 0, 0, 1, 7, 1, 7, 0);
    @(negedge Clock);
    check("fwd_mem", ForwardA_EX, 2'b10);
    tick();
    set_in(0, 0, 7, 0, 0, 0, 1, 0, 1, 7, 0);
    @(negedge Clock);
    check("fwd_wb", ForwardA_EX, 2'b01);
    tick();
    set_in(0, 0, 0, 4, 0, 0, 1, 0, 1, 4, 0);
    @(negedge Clock);
    check("fwd_r0_b_wb", {ForwardA_EX, ForwardB_EX}, 4'b0001);
    tick();

    Reset_n = 1'b0;
    idle();
    tick();
    Reset_n = 1'b1;
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick(3);
    idle();
    @(negedge Clock);
`ifdef HAZARD_PERF_CNT_EN
    check("stall3", StallCount, 32'd3);
`else
    check("stall3", StallCount, 32'd0);
`endif
    check("after_busy", PCWrite, 1'b1);
    tick();

    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (255) @(posedge Clock);
    @(negedge Clock);
    check("to_255", Timeout, 1'b0);
    @(posedge Clock);
    @(negedge Clock);
    check("to_256", Timeout, 1'b1);
    tick(44);
    idle();
    tick();
    @(negedge Clock);
    check("to_sticky", Timeout, 1'b1);
    tick();
    Reset_n = 1'b0;
    @(negedge Clock);
    check("to_reset", Timeout, 1'b0);
    tick();
    Reset_n = 1'b1;
    tick();

    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick(200);
    Reset_n = 1'b0;
    tick(2);
    Reset_n = 1'b1;
    tick(100);
    @(negedge Clock);
    check("to_abandon", Timeout, 1'b0);
    idle();
    tick();

    for (int i = 0; i < 300; i++) begin
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 5) == 0));
      tick();
    end
    idle();
    tick();

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 255: MEM_WAIT cycle limit before Timeout is raised.
REQ-002 Parameter CNT_W, default 32: width of the performance counters.
REQ-003 Clock  input  1  single rising-edge clock for all state.
REQ-004 Reset_n  input  1  asynchronous active-low reset.
REQ-005 Rs_ID, Rt_ID  input  5 each  source register fields of the instruction in decode.
REQ-006 Rs_EX, Rt_EX  input  5 each  source register fields in execute; Rt_EX is also the load destination.
REQ-007 R_Enable_EX  input  1  the instruction in execute is a load.
REQ-008 BranchTaken_EX  input  1  a branch or jump resolved taken in execute.
REQ-009 RegWrite_MEM, WriteReg_MEM  input  1, 5  writeback intent and destination in memory.
REQ-010 RegWrite_WB, WriteReg_WB  input  1, 5  writeback intent and destination in writeback.
REQ-011 MemBusy_MEM  input  1  data memory cannot complete this cycle.
REQ-012 PCWrite, IFID_Write, IDEX_Write, EXMEM_Write  output  1 each  register update enables.
REQ-013 IFID_Flush, IDEX_Flush, MEMWB_Bubble  output  1 each  insert a NOP into that pipeline register.
REQ-014 ForwardA_EX, ForwardB_EX  output  2 each  ALU operand source: 00 register file, 10 EX/MEM, 01 MEM/WB.
REQ-015 Timeout  output  1  sticky flag for a memory wait longer than MAX_WAIT.
REQ-016 StallCount, FlushCount  output  CNT_W each  performance counters.

Function
REQ-017 Module SHALL implement FSM states RUN, LU_BUBBLE and MEM_WAIT; control outputs are combinational from the state and the current inputs.
REQ-018 Hazard LU SHALL be defined as R_Enable_EX & (Rt_EX != 0) & (Rt_EX == Rs_ID | Rt_EX == Rt_ID).
REQ-019 Priority order SHALL be MemBusy_MEM, then BranchTaken_EX, then LU; this applies in every state.
REQ-020 MemBusy_MEM=1 SHALL drive all four write enables to 0 and MEMWB_Bubble to 1, and SHALL set next state to MEM_WAIT.
REQ-021 BranchTaken_EX=1 without MemBusy_MEM SHALL drive IFID_Flush=1, IDEX_Flush=1 and all write enables to 1; next state is RUN.
REQ-022 LU alone SHALL drive PCWrite=0, IFID_Write=0 and IDEX_Flush=1; next state is LU_BUBBLE.
REQ-023 In LU_BUBBLE, outputs SHALL match RUN behaviour; the next state is RUN, or the state selected by the higher-priority events.
REQ-024 MEM_WAIT SHALL hold while MemBusy_MEM=1, with an 8+-bit wait counter incrementing every cycle and saturating.
REQ-025 When the wait counter reaches MAX_WAIT, Timeout SHALL set on the next edge and stay set until reset.
REQ-026 When MemBusy_MEM falls, the FSM SHALL return to RUN that cycle, clear the wait counter, and evaluate the pending branch or LU normally.
REQ-027 ForwardA_EX SHALL be 10 if RegWrite_MEM & WriteReg_MEM != 0 & WriteReg_MEM == Rs_EX.
REQ-028 Otherwise ForwardA_EX SHALL be 01 on the equivalent WB match, else 00.
REQ-029 ForwardB_EX SHALL follow the ForwardA_EX rules using Rt_EX; the MEM match wins over the WB match.
REQ-030 Register 0 SHALL never be forwarded.

Reset
REQ-031 While Reset_n=0: state RUN, wait counter 0, Timeout 0, counters 0.
REQ-032 While Reset_n=0: all write enables 0, IFID_Flush, IDEX_Flush and MEMWB_Bubble 1, forwards 00.
REQ-033 Reset asserted mid-MEM_WAIT SHALL abandon the wait immediately, with no Timeout set.

Configuration
REQ-034 With HAZARD_PERF_CNT_EN defined, StallCount SHALL increment on each cycle where PCWrite=0.
REQ-035 With HAZARD_PERF_CNT_EN defined, FlushCount SHALL increment on each cycle where IFID_Flush=1 and Reset_n=1.
REQ-036 Both counters SHALL wrap modulo 2^CNT_W.
REQ-037 Without HAZARD_PERF_CNT_EN, both counter ports SHALL be constant 0 and no counter flops are inferred.

Verification
REQ-038 Load to r5 in EX, ID reads r5 as Rs -> one cycle of PCWrite=0 and IDEX_Flush=1, then LU_BUBBLE, then RUN.
REQ-039 Same load with Rt_EX=0 -> no stall.
REQ-040 LU and BranchTaken_EX in the same cycle -> both flushes asserted, PCWrite=1, no LU_BUBBLE.
REQ-041 MemBusy_MEM held 3 cycles -> enables 0 for 3 cycles, then RUN; StallCount=3 with the macro defined.
REQ-042 MemBusy_MEM held 300 cycles with MAX_WAIT=255 -> Timeout rises after cycle 256 and stays 1 until Reset_n=0.
REQ-043 WriteReg_MEM = WriteReg_WB = Rs_EX = 7, both RegWrite=1 -> ForwardA_EX=10; with WriteReg_MEM=0 -> ForwardA_EX=01.
